// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned DEF_NUM_LINES      = 32;
  localparam int unsigned DEF_WORDS_PER_LINE = 4;
  localparam int unsigned DEF_CNT_W          = 16;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    IDLE,
    REFILL
  } icache_state_t;

endpackage

// File: rtl/icache_fetch_unit_if.sv
// Read-only request/ready bus between the instruction cache and its backing memory.
interface icache_fetch_unit_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the instruction cache: one combinational read port,
// one synchronous write port and a synchronous clear of all valid bits.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = DEF_NUM_LINES,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int unsigned TAG_W          = 23,
  localparam int unsigned IDX_W         = $clog2(NUM_LINES),
  localparam int unsigned OFF_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data,
  input  logic             wr_set_valid,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= '0;
    end else if (wr_en && wr_set_valid) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays have no reset; a line is only ever read through
  // its valid bit, so clearing the storage itself would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
      if (wr_set_valid) begin
        tag_mem[wr_index] <= wr_tag;
      end
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache: combinational hits, stall-and-refill on a miss,
// one line fetched word by word from a multi-cycle backing memory.
module icache_fetch_unit
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = DEF_NUM_LINES,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc,
  output logic [31:0]         instr,
  output logic                stall,
  output logic [CNT_W-1:0]    miss_count,
  icache_fetch_unit_if.master mem
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 30 - OFF_W - IDX_W;
  localparam int unsigned LINE_W = TAG_W + IDX_W;

  logic [OFF_W-1:0]  pc_offset;
  logic [IDX_W-1:0]  pc_index;
  logic [TAG_W-1:0]  pc_tag;
  logic              unused_pc_bits;

  icache_state_t     state;
  logic [LINE_W-1:0] refill_line;
  logic [OFF_W-1:0]  beat;
  logic              last_beat;
  logic              beat_accept;

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [31:0]       line_data;
  logic              hit;

  assign pc_offset      = pc[2 +: OFF_W];
  assign pc_index       = pc[2+OFF_W +: IDX_W];
  assign pc_tag         = pc[31 -: TAG_W];
  assign unused_pc_bits = ^pc[1:0];

  assign hit         = (state == IDLE) && line_valid && (line_tag == pc_tag);
  assign last_beat   = (beat == OFF_W'(WORDS_PER_LINE - 1));
  assign beat_accept = mem.mem_req && mem.mem_ready;

  // Reset forces the fetch-side outputs quiet even before the state register settles.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    instr = NOP_INSTR;
    stall = 1'b0;
    if (!reset) begin
      if (hit) begin
        instr = line_data;
      end else begin
        stall = 1'b1;
      end
    end
  end

  assign mem.mem_req  = !reset && (state == REFILL);
  assign mem.mem_addr = mem.mem_req ? {refill_line, beat, 2'b00} : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      refill_line <= '0;
      beat        <= '0;
      miss_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            refill_line <= {pc_tag, pc_index};
            beat        <= '0;
            state       <= REFILL;
            if (miss_count != '1) begin
              miss_count <= miss_count + CNT_W'(1);
            end
          end
        end
        REFILL: begin
          if (mem.mem_ready) begin
            beat <= beat + OFF_W'(1);
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  icache_line_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_line_store (
    .clk          (clk),
    .clear        (reset),
    .rd_index     (pc_index),
    .rd_offset    (pc_offset),
    .rd_valid     (line_valid),
    .rd_tag       (line_tag),
    .rd_data      (line_data),
    .wr_en        (beat_accept),
    .wr_index     (refill_line[IDX_W-1:0]),
    .wr_offset    (beat),
    .wr_data      (mem.mem_rdata),
    .wr_set_valid (last_beat),
    .wr_tag       (refill_line[LINE_W-1 -: TAG_W])
  );

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Self-checking bench for icache_fetch_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural cache model.
module tb_icache_fetch_unit;
  import icache_pkg::*;

  localparam int NL         = 32;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = 4 * WPL;
  localparam int MAX_CNT    = 65535;
  localparam int SAT_MAX    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr, sat_instr;
  logic        stall, sat_stall;
  logic [15:0] miss_count;
  logic [1:0]  sat_miss_count;

  icache_fetch_unit_if bus_main ();
  icache_fetch_unit_if bus_sat ();

  icache_fetch_unit u_dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .stall      (stall),
    .miss_count (miss_count),
    .mem        (bus_main)
  );

  icache_fetch_unit #(.CNT_W(2)) u_sat (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (sat_instr),
    .stall      (sat_stall),
    .miss_count (sat_miss_count),
    .mem        (bus_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] word_addr);
    return 32'h1000 + word_addr;
  endfunction

  // Behavioural model: which lines hold which tag, and an outstanding refill.
  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  bit          m_refill;
  int unsigned m_base;
  int          m_beats;
  int          m_misses;
  bit          started = 1'b0;

  int unsigned e_idx, e_tag;
  bit          e_hit;
  logic        e_stall, e_req;
  logic [31:0] e_instr, e_addr;

  always @(negedge clk) begin
    if (started) begin
      e_idx = (pc / LINE_BYTES) % NL;
      e_tag = pc / (LINE_BYTES * NL);
      e_hit = !m_refill && m_valid[e_idx] && (m_tag[e_idx] == e_tag);
      if (reset) begin
        e_stall = 1'b0; e_instr = NOP_INSTR; e_req = 1'b0; e_addr = 32'h0;
      end else if (m_refill) begin
        e_stall = 1'b1; e_instr = NOP_INSTR; e_req = 1'b1;
        e_addr  = m_base + 32'(4 * m_beats);
      end else begin
        e_stall = !e_hit;
        e_instr = e_hit ? rom_word(pc >> 2) : NOP_INSTR;
        e_req   = 1'b0; e_addr = 32'h0;
      end
      check("instr", instr, e_instr);
      check("stall", stall, e_stall);
      check("mem_req", bus_main.mem_req, e_req);
      check("mem_addr", bus_main.mem_addr, e_addr);
      check("miss_count", miss_count, 32'(m_misses > MAX_CNT ? MAX_CNT : m_misses));
      check("sat_stall", sat_stall, e_stall);
      check("sat_miss_count", sat_miss_count, 32'(m_misses > SAT_MAX ? SAT_MAX : m_misses));

      if (reset) begin
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_refill = 1'b0;
        m_misses = 0;
      end else if (!m_refill) begin
        if (!e_hit) begin
          m_refill = 1'b1;
          m_base   = pc & ~32'(LINE_BYTES - 1);
          m_beats  = 0;
          m_misses++;
        end
      end else if (bus_main.mem_ready) begin
        m_beats++;
        if (m_beats == WPL) begin
          m_valid[(m_base / LINE_BYTES) % NL] = 1'b1;
          m_tag[(m_base / LINE_BYTES) % NL]   = m_base / (LINE_BYTES * NL);
          m_refill = 1'b0;
        end
      end
    end
  end

  // ready_mode: 0 = always ready, 1 = random, 2 = two idle cycles before each beat
  int          ready_mode = 0;
  int          wait_cnt   = 0;
  logic [31:0] req_log [$];

  task automatic drive(input logic [31:0] p, input logic r);
    logic rdy;
    @(posedge clk);
    #1;
    pc    = p;
    reset = r;
    case (ready_mode)
      0: rdy = 1'b1;
      1: rdy = 1'($urandom_range(0, 1));
      default: begin
        if (m_refill && !r) begin
          if (wait_cnt == 2) begin
            rdy = 1'b1; wait_cnt = 0;
          end else begin
            rdy = 1'b0; wait_cnt++;
          end
        end else begin
          rdy = 1'($urandom_range(0, 1)); wait_cnt = 0;
        end
      end
    endcase
    bus_main.mem_ready = rdy;
    bus_sat.mem_ready  = rdy;
    #1;
    bus_main.mem_rdata = bus_main.mem_req ? rom_word({2'b00, bus_main.mem_addr[31:2]}) : $urandom;
    bus_sat.mem_rdata  = bus_main.mem_rdata;
  endtask

  // Fetch p until it stops stalling; n = stall cycles, req_log = requested addresses.
  task automatic fill(input logic [31:0] p, output int n);
    req_log.delete();
    n = 0;
    drive(p, 1'b0);
    while (stall && n < 200) begin
      if (bus_main.mem_req) req_log.push_back(bus_main.mem_addr);
      n++;
      drive(p, 1'b0);
    end
    check("fill_bound_stall", stall, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    pc    = 32'h0;
    bus_main.mem_ready = 1'b1; bus_sat.mem_ready = 1'b1;
    bus_main.mem_rdata = 32'h0; bus_sat.mem_rdata = 32'h0;
    @(posedge clk);
    #1;
    started = 1'b1;

    // Reset-time outputs
    drive(32'h0, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_req", bus_main.mem_req, 1'b0);
    check("rst_addr", bus_main.mem_addr, 32'h0);
    check("rst_count", miss_count, 32'h0);

    // Cold miss
    fill(32'h0, n);
    check("cold_stall_cycles", 32'(n), 32'd5);
    check("cold_beats", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < req_log.size(); i++) check("cold_addr", req_log[i], 32'(4 * i));
    check("cold_instr", instr, 32'h1000);
    check("cold_count", miss_count, 32'd1);

    // Hit in the same line
    drive(32'hC, 1'b0);
    check("hit_instr", instr, 32'h1003);
    check("hit_stall", stall, 1'b0);
    check("hit_count", miss_count, 32'd1);

    // Conflict eviction on index 0
    fill(32'h200, n);
    check("conf_stall_cycles", 32'(n), 32'd5);
    check("conf_instr_a", instr, 32'h1080);
    fill(32'h0, n);
    check("conf_refill_cycles", 32'(n), 32'd5);
    check("conf_instr_b", instr, 32'h1000);
    check("conf_count", miss_count, 32'd3);

    // Backpressure: two not-ready cycles before each beat
    ready_mode = 2;
    wait_cnt   = 0;
    fill(32'h40, n);
    check("bp_stall_cycles", 32'(n), 32'd13);
    check("bp_req_cycles", 32'(req_log.size()), 32'd12);
    for (int i = 0; i < req_log.size(); i++) check("bp_addr", req_log[i], 32'h40 + 32'(4 * (i / 3)));
    check("bp_instr", instr, 32'h1010);
    ready_mode = 0;

    // Reset in the middle of a refill
    drive(32'h0, 1'b1);
    drive(32'h0, 1'b0);
    drive(32'h0, 1'b0);
    drive(32'h0, 1'b0);
    drive(32'h0, 1'b1);
    check("mid_rst_req", bus_main.mem_req, 1'b0);
    fill(32'h0, n);
    check("mid_rst_cycles", 32'(n), 32'd5);
    check("mid_rst_first_addr", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h0);
    check("mid_rst_count", miss_count, 32'd1);
    check("mid_rst_instr", instr, 32'h1000);

    // Saturation of the narrow counter
    drive(32'h0, 1'b1);
    for (int k = 1; k <= 5; k++) fill(32'(k * LINE_BYTES), n);
    check("sat_count", sat_miss_count, 32'd3);
    check("wide_count", miss_count, 32'd5);

    // Randomized traffic with conflicts, pc changes during stalls and sporadic reset
    ready_mode = 1;
    pc = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] np;
      np = pc;
      if ($urandom_range(0, 3) == 0)
        np = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 31)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      drive(np, ($urandom_range(0, 299) == 0));
    end

    @(posedge clk);
    #1;
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
